// File: rtl/aes_round_key_buf.sv
// aes_round_key_buf: drives the AES-128 key expander's load strobe, captures the NR+1
// round keys it produces on consecutive cycles, and serves them by index with
// 1-cycle latency so encrypt and decrypt can walk the schedule in either direction.
// Optional build macro AES_RKBUF_ZEROIZE_EN: adds a `zeroize` input and an async
// clear of the key table; without it the table has no reset.
module aes_round_key_buf #(
    parameter int unsigned NR   = 10,
    parameter int unsigned IDXW = 4
) (
    input  logic            clk,
    input  logic            rst,
`ifdef AES_RKBUF_ZEROIZE_EN
    input  logic            zeroize,
`endif
    input  logic            start,
    input  logic [127:0]    key,
    output logic            busy,
    output logic            ready,
    output logic            kx_ld,
    output logic [127:0]    kx_key,
    input  logic [31:0]     kx_w0,
    input  logic [31:0]     kx_w1,
    input  logic [31:0]     kx_w2,
    input  logic [31:0]     kx_w3,
    input  logic            rd_en,
    input  logic [IDXW-1:0] rd_idx,
    output logic            rd_valid,
    output logic [127:0]    rd_key,
    output logic            rd_err
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NR);

    typedef enum logic [1:0] {StIdle, StLoad, StCapt, StReady} state_e;

    state_e          state_q;
    logic [IDXW-1:0] cnt_q;
    logic [127:0]    rk_mem [NR+1];
    logic            zero_req;
    logic            capture;

`ifdef AES_RKBUF_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    assign busy = (state_q == StLoad) || (state_q == StCapt);

    // A restart or zeroize in the same cycle wins over the capture of that cycle.
    assign capture = (state_q == StCapt) && !start && !zero_req;

    // Control FSM: load strobe, capture counter and ready flag, all registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            kx_ld   <= 1'b0;
            kx_key  <= '0;
            ready   <= 1'b0;
        end else begin
            kx_ld <= 1'b0;
            if (zero_req) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                ready   <= 1'b0;
            end else if (start) begin
                // Also aborts an expansion in flight; captured entries become invalid.
                state_q <= StLoad;
                cnt_q   <= '0;
                kx_ld   <= 1'b1;
                kx_key  <= key;
                ready   <= 1'b0;
            end else begin
                case (state_q)
                    StLoad: begin
                        state_q <= StCapt;
                        cnt_q   <= '0;
                    end
                    StCapt: begin
                        if (cnt_q == LAST_IDX) begin
                            state_q <= StReady;
                            cnt_q   <= '0;
                            ready   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef AES_RKBUF_ZEROIZE_EN
    // Round key table, cleared by reset and by zeroize.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= int'(NR); i++) rk_mem[i] <= '0;
        end else if (zero_req) begin
            for (int i = 0; i <= int'(NR); i++) rk_mem[i] <= '0;
        end else if (capture) begin
            rk_mem[cnt_q] <= {kx_w0, kx_w1, kx_w2, kx_w3};
        end
    end
`else
    // Round key table, no reset: contents persist until overwritten.
    always_ff @(posedge clk) begin
        if (capture) begin
            rk_mem[cnt_q] <= {kx_w0, kx_w1, kx_w2, kx_w3};
        end
    end
`endif

    // Read port: response registered one cycle after rd_en; rd_key holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            rd_key   <= '0;
        end else if (rd_en) begin
            rd_valid <= 1'b1;
            if (ready && !zero_req && (rd_idx <= LAST_IDX)) begin
                rd_err <= 1'b0;
                rd_key <= rk_mem[rd_idx];
            end else begin
                rd_err <= 1'b1;
                rd_key <= '0;
            end
        end else begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end
    end

endmodule
